// File: rtl/cpu_io_bridge_if.sv
// VDP-side register request bus of cpu_io_bridge: the bridge is the master,
// the VDP core answers with read data and an acknowledge.
interface cpu_io_bridge_if #(
  parameter int PORT_BITS = 2
);
  logic                 vdp_req;
  logic                 vdp_wrt;
  logic [PORT_BITS-1:0] vdp_adr;
  logic [7:0]           vdp_dbo;
  logic [7:0]           vdp_dbi;
  logic                 vdp_ack;

  modport master (
    output vdp_req, vdp_wrt, vdp_adr, vdp_dbo,
    input  vdp_dbi, vdp_ack
  );

  modport slave (
    input  vdp_req, vdp_wrt, vdp_adr, vdp_dbo,
    output vdp_dbi, vdp_ack
  );
endinterface

// File: rtl/cpu_io_bridge.sv
// Z80 I/O-port bridge: decodes the port window, filters RD/WR strobes and issues one VDP request per bus cycle.
// Optional CPU wait-state output enabled by defining CPU_IO_BRIDGE_WAIT_EN.
module cpu_io_bridge #(
  parameter logic [7:0] BASE_ADDR    = 8'h98,
  parameter int         PORT_BITS    = 2,
  parameter int         FIFO_DEPTH   = 4,
  parameter int         FILTER_DEPTH = 3
) (
  input  logic                            clk_w,
  input  logic                            reset_n_w,
  input  logic [7:0]                      io_addr,
  input  logic                            iorq_n,
  input  logic                            rd_n,
  input  logic                            wr_n,
  input  logic [7:0]                      cd_in,
  output logic [7:0]                      cd_out,
  output logic                            cd_oe,
  output logic                            cs_n,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow,
`ifdef CPU_IO_BRIDGE_WAIT_EN
  output logic                            wait_n,
`endif
  cpu_io_bridge_if.master                 vdp
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = PORT_BITS + 8;
  localparam int CW = $clog2(FILTER_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t state, next_state;

  logic                 sel, rdr_n, wrr_n;
  logic [1:0]           sync1, sync2, filt, filt_d;
  logic [CW-1:0]        cnt [2];
  logic [PORT_BITS-1:0] adr_s1, adr_s2;
  logic [7:0]           dat_s1, dat_s2;
  logic                 rd_ev, wr_ev;

  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        count;
  logic                 full, push, pop, drop, wr_held;
  logic [EW-1:0]        wr_entry, wr_entry_mux, head;

  logic                 rd_pending, rd_done;
  logic [PORT_BITS-1:0] rd_port;
  logic [7:0]           rd_data;
  logic                 ovf;

  assign sel   = (io_addr[7:PORT_BITS] == BASE_ADDR[7:PORT_BITS]) & ~iorq_n;
  assign cs_n  = ~sel;
  assign rdr_n = ~(sel & ~rd_n);
  assign wrr_n = ~(sel & ~wr_n);
  assign cd_oe = ~rdr_n;

  // Index 0 is the read strobe, index 1 the write strobe; address/data ride
  // alongside the synchroniser so the captured entry lines up with the strobe.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_d <= 2'b11;
      cnt[0] <= '0;
      cnt[1] <= '0;
      adr_s1 <= '0;
      adr_s2 <= '0;
      dat_s1 <= '0;
      dat_s2 <= '0;
    end else begin
      sync1  <= {wrr_n, rdr_n};
      sync2  <= sync1;
      filt_d <= filt;
      adr_s1 <= io_addr[PORT_BITS-1:0];
      adr_s2 <= adr_s1;
      dat_s1 <= cd_in;
      dat_s2 <= dat_s1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(FILTER_DEPTH - 1)) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // A falling edge only counts while the other filtered strobe is inactive.
  assign rd_ev = filt_d[0] & ~filt[0] & filt[1];
  assign wr_ev = filt_d[1] & ~filt[1] & filt[0];

  assign full         = (count == LW'(FIFO_DEPTH));
  assign pop          = (state == WR) & vdp.vdp_ack;
  assign rd_done      = (state == RD) & vdp.vdp_ack;
  assign head         = mem[rd_ptr];
  assign wr_entry_mux = wr_ev ? {adr_s2, dat_s2} : wr_entry;
  assign push         = (wr_ev | wr_held) & (~full | pop);

`ifdef CPU_IO_BRIDGE_WAIT_EN
  logic rd_served, wr_served;

  // A write arriving at a full FIFO is parked until a slot frees up.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      wr_held   <= 1'b0;
      rd_served <= 1'b0;
      wr_served <= 1'b0;
    end else begin
      wr_held <= (wr_ev | wr_held) & ~push;
      if (rdr_n)        rd_served <= 1'b0;
      else if (rd_done) rd_served <= 1'b1;
      if (wrr_n)        wr_served <= 1'b0;
      else if (push)    wr_served <= 1'b1;
    end
  end

  assign drop   = 1'b0;
  assign wait_n = ~((sel & ~wr_n & ~wr_served & (full | wr_held)) |
                    (sel & ~rd_n & ~rd_served));
`else
  assign wr_held = 1'b0;
  assign drop    = wr_ev & ~push;
`endif

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wr_entry <= '0;
      ovf      <= 1'b0;
    end else begin
      if (wr_ev) wr_entry <= {adr_s2, dat_s2};
      if (push) begin
        mem[wr_ptr] <= wr_entry_mux;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

  assign fifo_level = count;
  assign overflow   = ovf;

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      rd_pending <= 1'b0;
      rd_port    <= '0;
      rd_data    <= '0;
    end else begin
      if (rd_ev && !rd_pending) begin
        rd_pending <= 1'b1;
        rd_port    <= adr_s2;
      end else if (rd_done) begin
        rd_pending <= 1'b0;
      end
      if (rd_done) rd_data <= vdp.vdp_dbi;
    end
  end

  assign cd_out = rd_data;

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) state <= IDLE;
    else            state <= next_state;
  end

  // Queued writes go first so the VDP sees accesses in CPU order; a same-cycle
  // push or read event is looked at directly to save a cycle of latency.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (count != '0 || push)      next_state = WR;
        else if (rd_pending || rd_ev) next_state = RD;
      end
      WR:      if (vdp.vdp_ack) next_state = IDLE;
      RD:      if (vdp.vdp_ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    vdp.vdp_req = 1'b0;
    vdp.vdp_wrt = 1'b0;
    vdp.vdp_adr = '0;
    vdp.vdp_dbo = '0;
    case (state)
      WR: begin
        vdp.vdp_req = 1'b1;
        vdp.vdp_wrt = 1'b1;
        vdp.vdp_adr = head[EW-1:8];
        vdp.vdp_dbo = head[7:0];
      end
      RD: begin
        vdp.vdp_req = 1'b1;
        vdp.vdp_adr = rd_port;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Scoreboard bench for cpu_io_bridge: directed CPU bus cycles, expected VDP requests queued and checked by a monitor.
// The wait-state scenario is built when CPU_IO_BRIDGE_WAIT_EN is defined.
module tb_cpu_io_bridge;

  typedef struct {
    logic       wrt;
    logic [1:0] adr;
    logic [7:0] dbo;
  } req_t;

  logic       clk_w = 1'b0;
  logic       reset_n_w;
  logic [7:0] io_addr, cd_in, cd_out;
  logic       iorq_n, rd_n, wr_n, cd_oe, cs_n, overflow;
  logic [2:0] fifo_level;
`ifdef CPU_IO_BRIDGE_WAIT_EN
  logic       wait_n;
`endif

  int   checks = 0;
  int   errors = 0;
  int   req_count = 0;
  int   req_cycles = 0;
  int   req_before;
  bit   ack_en = 1'b0;
  bit   prev_req = 1'b0;
  bit   rd_ack_last = 1'b0;
  logic [7:0] rd_exp_data = 8'h00;
  req_t exp_q[$];

  cpu_io_bridge_if #(.PORT_BITS(2)) bus ();

  cpu_io_bridge dut (
    .clk_w      (clk_w),
    .reset_n_w  (reset_n_w),
    .io_addr    (io_addr),
    .iorq_n     (iorq_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .cd_in      (cd_in),
    .cd_out     (cd_out),
    .cd_oe      (cd_oe),
    .cs_n       (cs_n),
    .fifo_level (fifo_level),
    .overflow   (overflow),
`ifdef CPU_IO_BRIDGE_WAIT_EN
    .wait_n     (wait_n),
`endif
    .vdp        (bus.master)
  );

  always #5 clk_w = ~clk_w;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic push_exp(input logic wrt, input logic [1:0] adr, input logic [7:0] dbo);
    req_t e;
    e.wrt = wrt;
    e.adr = adr;
    e.dbo = dbo;
    exp_q.push_back(e);
  endtask

  task automatic bus_start(input logic [7:0] addr, input bit wr, input bit rd, input logic [7:0] data);
    @(negedge clk_w);
    io_addr = addr;
    cd_in   = data;
    iorq_n  = 1'b0;
    wr_n    = ~wr;
    rd_n    = ~rd;
  endtask

  task automatic bus_end(input int gap);
    iorq_n = 1'b1;
    wr_n   = 1'b1;
    rd_n   = 1'b1;
    repeat (gap) @(negedge clk_w);
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input bit wr, input bit rd, input logic [7:0] data, input int hold);
    bus_start(addr, wr, rd, data);
    repeat (hold) @(negedge clk_w);
    bus_end(4);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((fifo_level != 0 || bus.vdp_req || exp_q.size() != 0) && n < bound) begin
      @(negedge clk_w);
      n++;
    end
    checkOutput("drain_in_time", (n < bound), 1);
    repeat (3) @(negedge clk_w);
  endtask

  // Monitor and VDP responder share one process so ack generation and the
  // cd_out check after a read ack happen in a fixed order each cycle.
  always @(negedge clk_w) begin
    req_t e;
    if (rd_ack_last) checkOutput("cd_out_after_ack", cd_out, rd_exp_data);
    if (bus.vdp_req && !prev_req) begin
      req_count++;
      checkOutput("req_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("req_wrt", bus.vdp_wrt, e.wrt);
        checkOutput("req_adr", bus.vdp_adr, e.adr);
        if (e.wrt) checkOutput("req_dbo", bus.vdp_dbo, e.dbo);
      end
    end
    prev_req    = bus.vdp_req;
    req_cycles  = bus.vdp_req ? req_cycles + 1 : 0;
    bus.vdp_ack = bus.vdp_req && ack_en && (req_cycles >= 2);
    rd_ack_last = bus.vdp_ack && !bus.vdp_wrt;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    reset_n_w   = 1'b0;
    io_addr     = 8'h00;
    cd_in       = 8'h00;
    iorq_n      = 1'b1;
    rd_n        = 1'b1;
    wr_n        = 1'b1;
    bus.vdp_ack = 1'b0;
    bus.vdp_dbi = 8'h00;
    repeat (3) @(negedge clk_w);
    checkOutput("rst_vdp_req", bus.vdp_req, 0);
    checkOutput("rst_vdp_wrt", bus.vdp_wrt, 0);
    checkOutput("rst_fifo_level", fifo_level, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_cd_out", cd_out, 0);
    checkOutput("rst_cs_n", cs_n, 1);
    reset_n_w = 1'b1;
    repeat (2) @(negedge clk_w);

    $display("[TB] single write to port 1");
    ack_en     = 1'b1;
    req_before = req_count;
    push_exp(1'b1, 2'd1, 8'h5A);
    applyStimulus(8'h99, 1'b1, 1'b0, 8'h5A, 10);
    wait_idle(100);
    checkOutput("single_req_count", req_count - req_before, 1);
    checkOutput("single_fifo_level", fifo_level, 0);

    $display("[TB] short write glitch");
    req_before = req_count;
    applyStimulus(8'h98, 1'b1, 1'b0, 8'hEE, 2);
    repeat (10) @(negedge clk_w);
    checkOutput("glitch_req_count", req_count - req_before, 0);
    checkOutput("glitch_fifo_level", fifo_level, 0);

`ifndef CPU_IO_BRIDGE_WAIT_EN
    $display("[TB] overflow with stalled VDP");
    ack_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) push_exp(1'b1, 2'd0, 8'(i));
      applyStimulus(8'h98, 1'b1, 1'b0, 8'(i), 10);
    end
    checkOutput("ovf_fifo_level", fifo_level, 4);
    checkOutput("ovf_flag", overflow, 1);
    ack_en = 1'b1;
    wait_idle(200);
    checkOutput("ovf_drained_level", fifo_level, 0);
    checkOutput("ovf_sticky", overflow, 1);
`else
    $display("[TB] wait state on full FIFO");
    ack_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      push_exp(1'b1, 2'd0, 8'(i));
      applyStimulus(8'h98, 1'b1, 1'b0, 8'(i), 10);
    end
    checkOutput("wait_fifo_level", fifo_level, 4);
    push_exp(1'b1, 2'd2, 8'h55);
    bus_start(8'h9A, 1'b1, 1'b0, 8'h55);
    repeat (3) @(negedge clk_w);
    checkOutput("wait_asserted", wait_n, 0);
    ack_en = 1'b1;
    n = 0;
    while (!wait_n && n < 50) begin
      @(negedge clk_w);
      n++;
    end
    checkOutput("wait_released", wait_n, 1);
    repeat (10) @(negedge clk_w);
    bus_end(4);
    wait_idle(200);
    checkOutput("wait_no_overflow", overflow, 0);
`endif

    $display("[TB] read queued behind writes");
    ack_en = 1'b0;
    push_exp(1'b1, 2'd1, 8'hAA);
    push_exp(1'b1, 2'd2, 8'hBB);
    applyStimulus(8'h99, 1'b1, 1'b0, 8'hAA, 10);
    applyStimulus(8'h9A, 1'b1, 1'b0, 8'hBB, 10);
    bus.vdp_dbi = 8'hC3;
    rd_exp_data = 8'hC3;
    push_exp(1'b0, 2'd1, 8'h00);
    bus_start(8'h99, 1'b0, 1'b1, 8'h00);
    @(negedge clk_w);
    checkOutput("rd_cd_oe_active", cd_oe, 1);
    repeat (10) @(negedge clk_w);
    checkOutput("rd_fifo_level", fifo_level, 2);
    bus_end(1);
    checkOutput("rd_cd_oe_idle", cd_oe, 0);
    ack_en = 1'b1;
    wait_idle(200);
    checkOutput("rd_cd_out", cd_out, 8'hC3);

    $display("[TB] decode miss and conflicting strobes");
    req_before = req_count;
    bus_start(8'h9C, 1'b1, 1'b0, 8'h11);
    @(negedge clk_w);
    checkOutput("miss_cs_n", cs_n, 1);
    repeat (9) @(negedge clk_w);
    bus_end(2);
    bus_start(8'h98, 1'b1, 1'b1, 8'h22);
    @(negedge clk_w);
    checkOutput("both_cs_n", cs_n, 0);
    repeat (9) @(negedge clk_w);
    bus_end(10);
    checkOutput("decode_req_count", req_count - req_before, 0);
    checkOutput("decode_fifo_level", fifo_level, 0);

    $display("[TB] reset during write request");
    ack_en = 1'b0;
    push_exp(1'b1, 2'd3, 8'h77);
    applyStimulus(8'h9B, 1'b1, 1'b0, 8'h77, 10);
    n = 0;
    while (!bus.vdp_req && n < 20) begin
      @(negedge clk_w);
      n++;
    end
    checkOutput("rst_mid_req_seen", bus.vdp_req, 1);
    reset_n_w = 1'b0;
    #1;
    checkOutput("rst_mid_vdp_req", bus.vdp_req, 0);
    checkOutput("rst_mid_fifo_level", fifo_level, 0);
    checkOutput("rst_mid_cd_out", cd_out, 0);
    @(negedge clk_w);
    reset_n_w = 1'b1;
    repeat (3) @(negedge clk_w);
    checkOutput("rst_mid_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_io_bridge.md
Name: cpu_io_bridge

Overview:
- Parametrised Z80 I/O-port bridge between the raw CPU bus pins and the VDP register interface.
- Decodes a port window, glitch-filters the RD/WR strobes and turns each bus cycle into exactly one VDP request.
- Buffers writes in a small FIFO, serialises reads behind queued writes, and holds read data on the bus.
- Sits between the top-level pins and the VDP core, in the clk_w domain.

Parameters:
- BASE_ADDR, 8'h98: port window base; must be aligned to 2**PORT_BITS.
- PORT_BITS, 2: number of register-select bits; the window holds 2**PORT_BITS ports.
- FIFO_DEPTH, 4: write FIFO entries; power of two, at least 2.
- FILTER_DEPTH, 3: consecutive identical samples required to change a filtered strobe; at least 1.

Ports:
- clk_w, input, 1: pixel/VDP clock.
- reset_n_w, input, 1: asynchronous active-low reset.
- io_addr, input, 8: CPU A7..A0.
- iorq_n, input, 1: CPU I/O request.
- rd_n, input, 1: CPU read strobe.
- wr_n, input, 1: CPU write strobe.
- cd_in, input, 8: CPU data bus, input side.
- cd_out, output, 8: read data to the CPU bus.
- cd_oe, output, 1: bus drive enable.
- cs_n, output, 1: decoded chip select (combinational).
- vdp_req, output, 1: request to VDP.
- vdp_wrt, output, 1: 1 = write, 0 = read; valid while vdp_req is high.
- vdp_adr, output, PORT_BITS: register select.
- vdp_dbo, output, 8: write data.
- vdp_dbi, input, 8: read data from VDP; valid when vdp_ack is high.
- vdp_ack, input, 1: completes the current request.
- fifo_level, output, $clog2(FIFO_DEPTH)+1: occupied FIFO entries.
- overflow, output, 1: sticky write-drop flag.

Behaviour:
- Address decode: sel = (io_addr[7:PORT_BITS] == BASE_ADDR[7:PORT_BITS]) & ~iorq_n. cs_n = ~sel, purely combinational.
- Raw strobes: rdr_n = ~(sel & ~rd_n); wrr_n = ~(sel & ~wr_n).
- Synchronisation: each raw strobe passes through a 2-flop synchroniser, then a stability counter. The filtered output changes only after FILTER_DEPTH consecutive synchronised samples at the new level. The filter resets to 1 (inactive).
- Events: a bus event fires on the cycle the filtered strobe falls 1 to 0.
  - If both filtered strobes are low in the same cycle, no event fires.
  - Only one event is generated per strobe low period.
- Write event:
  - Captures {io_addr[PORT_BITS-1:0], cd_in} from the synchroniser-aligned registered copies.
  - Pushes the entry into the FIFO on the same cycle.
  - If the FIFO is full, the entry is dropped and overflow is set. overflow is cleared only by reset.
- Read event:
  - Sets rd_pending and latches the port.
  - A second read event while rd_pending is set is ignored.
- Drain FSM states: IDLE, WR, RD.
  - IDLE -> WR when the FIFO is non-empty. Writes take priority, which keeps CPU order.
  - IDLE -> RD when the FIFO is empty and rd_pending is set.
  - WR: vdp_req=1, vdp_wrt=1; vdp_adr/vdp_dbo come from the FIFO head and are held stable. On vdp_ack: pop, return to IDLE.
  - RD: vdp_req=1, vdp_wrt=0. On vdp_ack: rd_data <= vdp_dbi, clear rd_pending, return to IDLE.
  - A request is held until vdp_ack arrives. An ack in the first request cycle completes that cycle. vdp_ack is ignored in IDLE.
  - The minimum spacing between requests is one IDLE cycle.
- Latency:
  - Write event in cycle N with an empty FIFO and FSM in IDLE: vdp_req rises in cycle N+1.
  - Read event in cycle N with an empty FIFO: vdp_req rises in cycle N+1. The new data appears on cd_out the cycle after vdp_ack.
- Simultaneous push and pop: allowed. fifo_level is unchanged, and a push into a full FIFO in the same cycle as a pop succeeds.
- Pointers: wrap modulo FIFO_DEPTH; fifo_level is count-based.
- Bus drive: cd_out = rd_data (registered). cd_oe = ~rdr_n, combinational from the raw strobe so the bus drives immediately.
- Reset values:
  - vdp_req=0, vdp_wrt=0, vdp_adr=0, vdp_dbo=0.
  - rd_data=0, cd_out=0, fifo_level=0, overflow=0.
  - FSM=IDLE, FIFO empty, rd_pending=0.
- Reset asserted mid-request: vdp_req drops asynchronously and queued writes are discarded.

Optional Feature:
- Macro: CPU_IO_BRIDGE_WAIT_EN.
- When defined, adds port wait_n (output, 1, open-drain intent; the top level tristates it). wait_n=0 while either:
  - sel & ~wr_n & FIFO full, or
  - sel & ~rd_n & (rd_pending or read event not yet completed).
- With WAIT_EN, writes never overflow, and the CPU receives fresh read data on the same bus cycle.
- When not defined: no wait_n port. Read data returned is from the previous completed read unless CPU timing allows the read to complete first.

Test Plan:
- Reset, then one write to io_addr=8'h99, cd_in=8'h5A, held 10 cycles -> vdp_req pulse with vdp_wrt=1, vdp_adr=1, vdp_dbo=8'h5A; single request only; fifo_level returns to 0.
- wr_n glitch low for FILTER_DEPTH-1=2 cycles -> no event, fifo_level stays 0, vdp_req stays 0.
- vdp_ack held low, 5 writes (8'h01..8'h05) to port 0 -> 4 queued, overflow=1. After acks, vdp_dbo sequence is 01,02,03,04.
- Two writes queued, then a read of port 1 with vdp_dbi=8'hC3 -> both writes are issued before the read. cd_out=8'hC3 the cycle after the read ack. cd_oe follows the raw read strobe.
- Access to io_addr=8'h9C, and rd_n and wr_n low together at 8'h98 -> cs_n=1 for 9C; no event and no vdp_req in both cases.
- With CPU_IO_BRIDGE_WAIT_EN: FIFO full with a write active -> wait_n=0 until the pop, then the write is accepted and overflow stays 0. Assert reset_n_w during WR -> vdp_req=0 immediately, fifo_level=0.
